alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit integer ALU (AND/OR/XOR/NOR/ADD/SUB/SLT/SRL) between two requesters, A and B. Accepts at most one operation per cycle through a valid/ready handshake and registers the operands. Returns the registered result to the issuing requester two cycles after acceptance. Sits in the integer calc path between the two issuing units and the shared ALU datapath.

---
 rtl/alu_share_arb_if.sv | 17 +
 rtl/alu_share_arb.sv | 79 +++++++
 tb/tb_alu_share_arb.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response bus between two requesters and the shared ALU arbiter
interface alu_share_arb_if;
   logic        a_valid, a_ready, a_rsp_valid;
   logic        b_valid, b_ready, b_rsp_valid;
   logic [2:0]  a_op, b_op;
   logic [31:0] a_in1, a_in2, b_in1, b_in2;
   logic [31:0] rsp_data;
   logic        rsp_zero, rsp_ovf;
   modport master (
      output a_valid, a_op, a_in1, a_in2, b_valid, b_op, b_in1, b_in2,
      input  a_ready, a_rsp_valid, b_ready, b_rsp_valid, rsp_data, rsp_zero, rsp_ovf
   );
   modport slave (
      input  a_valid, a_op, a_in1, a_in2, b_valid, b_op, b_in1, b_in2,
      output a_ready, a_rsp_valid, b_ready, b_rsp_valid, rsp_data, rsp_zero, rsp_ovf
   );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one 32-bit ALU between requesters A and B, 2-cycle result latency
module alu_share_arb (
   input logic             clk,
   input logic             rst,
   alu_share_arb_if.slave  bus
);
   logic        last_q, last_d;
   logic        grant_a, grant_b;
   logic        s1_v_q, s1_id_q;
   logic [2:0]  s1_op_q;
   logic [31:0] s1_in1_q, s1_in2_q;
   logic        s2_v_q, s2_id_q, zero_q, ovf_q;
   logic [31:0] data_q;
   logic [31:0] add, sub, res;
   logic        ovf;
   // grant the lone requester, or on contention the one not granted last (last_q=1 means B)
   always_comb begin
      grant_a = !rst && bus.a_valid && (!bus.b_valid || last_q);
      grant_b = !rst && bus.b_valid && (!bus.a_valid || !last_q);
      last_d  = grant_a ? 1'b0 : grant_b ? 1'b1 : last_q;
   end
   // shared ALU evaluated on the S1 operands; overflow only meaningful for ADD/SUB
   always_comb begin
      add = s1_in1_q + s1_in2_q;
      sub = s1_in1_q - s1_in2_q;
      res = '0;
      ovf = 1'b0;
      case (s1_op_q)
         3'b000: res = s1_in1_q & s1_in2_q;
         3'b001: res = s1_in1_q | s1_in2_q;
         3'b100: res = s1_in1_q ^ s1_in2_q;
         3'b101: res = ~(s1_in1_q | s1_in2_q);
         3'b010: begin
            res = add;
            ovf = (s1_in1_q[31] == s1_in2_q[31]) && (add[31] != s1_in1_q[31]);
         end
         3'b110: begin
            res = sub;
            ovf = (s1_in1_q[31] != s1_in2_q[31]) && (sub[31] != s1_in1_q[31]);
         end
         3'b111: res = {31'b0, $signed(s1_in1_q) < $signed(s1_in2_q)};
         3'b011: res = s1_in2_q >> s1_in1_q[4:0];
      endcase
   end
   // two-stage pipe: S1 captures the granted op, S2 captures the result; response regs hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         data_q <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         last_q <= last_d;
         s1_v_q <= grant_a || grant_b;
         if (grant_a || grant_b) begin
            s1_id_q  <= grant_b;
            s1_op_q  <= grant_b ? bus.b_op  : bus.a_op;
            s1_in1_q <= grant_b ? bus.b_in1 : bus.a_in1;
            s1_in2_q <= grant_b ? bus.b_in2 : bus.a_in2;
         end
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_id_q <= s1_id_q;
            data_q  <= res;
            zero_q  <= res == '0;
            ovf_q   <= ovf;
         end
      end
   end
   assign bus.a_ready     = grant_a;
   assign bus.b_ready     = grant_b;
   assign bus.a_rsp_valid = s2_v_q && !s2_id_q;
   assign bus.b_rsp_valid = s2_v_q && s2_id_q;
   assign bus.rsp_data    = data_q;
   assign bus.rsp_zero    = zero_q;
   assign bus.rsp_ovf     = ovf_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed checks of arbitration, latency, ALU results and reset behaviour
module tb_alu_share_arb;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [2:0]  s_op [4];
   logic [31:0] s_x [4], s_y [4], s_r [4];
   logic        s_o [4];
   alu_share_arb_if bus ();
   alu_share_arb dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
   endtask
   task automatic drive_a(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      bus.a_valid = 1'b1; bus.a_op = op; bus.a_in1 = x; bus.a_in2 = y;
   endtask
   task automatic drive_b(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      bus.b_valid = 1'b1; bus.b_op = op; bus.b_in1 = x; bus.b_in2 = y;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      drive_a(3'b010, 32'd1, 32'd1);
      drive_b(3'b010, 32'd1, 32'd1);
      #1;
      chk("rst a_ready", bus.a_ready, 0);
      chk("rst b_ready", bus.b_ready, 0);
      step();
      idle();
      step();
      chk("rst a_rsp_valid", bus.a_rsp_valid, 0);
      chk("rst b_rsp_valid", bus.b_rsp_valid, 0);
      chk("rst rsp_data", bus.rsp_data, 0);
      chk("rst rsp_zero", bus.rsp_zero, 0);
      chk("rst rsp_ovf", bus.rsp_ovf, 0);
      rst = 1'b0;
   endtask
   task automatic run_seq(input bit sel_b, input string nm);
      for (int c = 0; c < 6; c++) begin
         idle();
         if (c < 4) begin
            if (sel_b) drive_b(s_op[c], s_x[c], s_y[c]);
            else drive_a(s_op[c], s_x[c], s_y[c]);
         end
         #1;
         if (c < 4) chk({nm, " ready"}, sel_b ? bus.b_ready : bus.a_ready, 1);
         if (c >= 2) begin
            chk({nm, " rsp_valid"}, sel_b ? bus.b_rsp_valid : bus.a_rsp_valid, 1);
            chk({nm, " other rsp_valid"}, sel_b ? bus.a_rsp_valid : bus.b_rsp_valid, 0);
            chk({nm, " data"}, bus.rsp_data, s_r[c-2]);
            chk({nm, " ovf"}, bus.rsp_ovf, s_o[c-2]);
            chk({nm, " zero"}, bus.rsp_zero, s_r[c-2] == 0);
         end
         step();
      end
   endtask
   initial begin
      idle();
      bus.a_op = 0; bus.a_in1 = 0; bus.a_in2 = 0;
      bus.b_op = 0; bus.b_in1 = 0; bus.b_in2 = 0;
      rst = 1'b1;
      step();
      do_reset();
      // single A AND
      drive_a(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      #1;
      chk("single a_ready", bus.a_ready, 1);
      chk("single b_ready", bus.b_ready, 0);
      step();
      idle();
      #1;
      chk("idle readies", {bus.a_ready, bus.b_ready}, 0);
      chk("single c1 a_rsp", bus.a_rsp_valid, 0);
      step();
      chk("single c2 a_rsp", bus.a_rsp_valid, 1);
      chk("single c2 b_rsp", bus.b_rsp_valid, 0);
      chk("single c2 data", bus.rsp_data, 32'hF000_F000);
      chk("single c2 zero", bus.rsp_zero, 0);
      step();
      chk("single c3 a_rsp", bus.a_rsp_valid, 0);
      chk("single c3 hold", bus.rsp_data, 32'hF000_F000);
      // contention after reset: A 1+2, B 5-5, grants alternate starting with A
      do_reset();
      for (int c = 0; c < 8; c++) begin
         idle();
         if (c < 6) begin
            drive_a(3'b010, 32'd1, 32'd2);
            drive_b(3'b110, 32'd5, 32'd5);
         end
         #1;
         if (c < 6) begin
            chk("cont a_ready", bus.a_ready, (c % 2) == 0);
            chk("cont b_ready", bus.b_ready, (c % 2) == 1);
         end
         if (c >= 2) begin
            chk("cont a_rsp", bus.a_rsp_valid, (c % 2) == 0);
            chk("cont b_rsp", bus.b_rsp_valid, (c % 2) == 1);
            chk("cont data", bus.rsp_data, (c % 2) == 0 ? 32'd3 : 32'd0);
            chk("cont zero", bus.rsp_zero, (c % 2) == 1);
         end
         step();
      end
      // overflow / SLT / SRL on A, back to back
      do_reset();
      s_op[0] = 3'b010; s_x[0] = 32'h7FFF_FFFF; s_y[0] = 32'd1;          s_r[0] = 32'h8000_0000; s_o[0] = 1;
      s_op[1] = 3'b110; s_x[1] = 32'h8000_0000; s_y[1] = 32'd1;          s_r[1] = 32'h7FFF_FFFF; s_o[1] = 1;
      s_op[2] = 3'b111; s_x[2] = 32'hFFFF_FFFF; s_y[2] = 32'd1;          s_r[2] = 32'd1;         s_o[2] = 0;
      s_op[3] = 3'b011; s_x[3] = 32'd4;         s_y[3] = 32'h8000_0000;  s_r[3] = 32'h0800_0000; s_o[3] = 0;
      run_seq(1'b0, "arith");
      // B back to back logic ops
      s_op[0] = 3'b000; s_r[0] = 32'h0A0A_0A0A;
      s_op[1] = 3'b001; s_r[1] = 32'hAFAF_AFAF;
      s_op[2] = 3'b100; s_r[2] = 32'hA5A5_A5A5;
      s_op[3] = 3'b101; s_r[3] = 32'h5050_5050;
      for (int i = 0; i < 4; i++) begin
         s_x[i] = 32'hAAAA_AAAA; s_y[i] = 32'h0F0F_0F0F; s_o[i] = 0;
      end
      run_seq(1'b1, "logic");
      // reset mid-flight drops the accepted op
      do_reset();
      drive_a(3'b010, 32'd1, 32'd2);
      drive_b(3'b110, 32'd9, 32'd4);
      #1;
      chk("mid a_ready", bus.a_ready, 1);
      step();
      bus.a_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid b_ready in rst", bus.b_ready, 0);
      step();
      rst = 1'b0;
      drive_a(3'b000, 32'hFFFF_0000, 32'h0FF0_0FF0);
      #1;
      chk("mid c2 a_rsp", bus.a_rsp_valid, 0);
      chk("mid c2 b_rsp", bus.b_rsp_valid, 0);
      chk("mid c2 data", bus.rsp_data, 0);
      chk("mid a first", bus.a_ready, 1);
      chk("mid b waits", bus.b_ready, 0);
      step();
      bus.a_valid = 1'b0;
      #1;
      chk("mid c3 a_rsp", bus.a_rsp_valid, 0);
      chk("mid c3 b_rsp", bus.b_rsp_valid, 0);
      chk("mid c3 b_ready", bus.b_ready, 1);
      step();
      idle();
      chk("mid c4 a_rsp", bus.a_rsp_valid, 1);
      chk("mid c4 data", bus.rsp_data, 32'h0FF0_0000);
      step();
      chk("mid c5 b_rsp", bus.b_rsp_valid, 1);
      chk("mid c5 data", bus.rsp_data, 32'd5);
      step();
      // stall/hold: B alone, then A wins, B's unsampled operands change before its grant
      do_reset();
      drive_b(3'b010, 32'd10, 32'd20);
      #1;
      chk("hold b first", bus.b_ready, 1);
      step();
      drive_b(3'b010, 32'd7, 32'd7);
      drive_a(3'b110, 32'd50, 32'd8);
      #1;
      chk("hold a granted", bus.a_ready, 1);
      chk("hold b waits", bus.b_ready, 0);
      step();
      bus.a_valid = 1'b0;
      drive_b(3'b010, 32'd100, 32'd200);
      #1;
      chk("hold b granted", bus.b_ready, 1);
      chk("hold c2 b_rsp", bus.b_rsp_valid, 1);
      chk("hold c2 data", bus.rsp_data, 32'd30);
      step();
      idle();
      chk("hold c3 a_rsp", bus.a_rsp_valid, 1);
      chk("hold c3 data", bus.rsp_data, 32'd42);
      step();
      chk("hold c4 b_rsp", bus.b_rsp_valid, 1);
      chk("hold c4 data", bus.rsp_data, 32'd300);
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
